// File: rtl/sram_rd_addr_gen_pkg.sv
// sram_pkg: shared state encoding and default sizes for the SRAM read-address generator
package sram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int ADDR_W_DEF  = 8;
  localparam int LEN_W_DEF   = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int MAX_OUT_DEF = 2;
endpackage

// File: rtl/sram_rd_addr_gen_out_cnt.sv
// sram_out_cnt: saturating outstanding-burst counter with look-ahead room/empty flags
module sram_out_cnt #(
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic o_room,
  output logic o_empty
);
  localparam int W = $clog2(MAX_OUT + 1);
  localparam logic [W-1:0] MAX = W'(MAX_OUT);
  logic [W-1:0] cnt, nxt;
  logic up, dn;
  // next count: increments stop at MAX_OUT, a stray decrement at zero is dropped
  always_comb begin
    up  = inc & (cnt != MAX);
    dn  = dec & (cnt != '0);
    nxt = (up == dn) ? cnt : up ? cnt + 1'b1 : cnt - 1'b1;
  end
  // outstanding count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= nxt;
  // flags describe the count after this edge so registered outputs can react in the same cycle
  assign o_room  = nxt != MAX;
  assign o_empty = nxt == '0;
endmodule

// File: rtl/sram_rd_addr_gen.sv
// sram_rd_addr_gen: AR-channel burst address generator with outstanding-burst throttling
module sram_rd_addr_gen
  import sram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic              i_aclk,
  input  logic              i_areset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_cfg_base,
  input  logic [ADDR_W-1:0] i_cfg_stride,
  input  logic [LEN_W-1:0]  i_cfg_len,
  input  logic [CNT_W-1:0]  i_cfg_count,
  input  logic              i_cfg_wrap,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [LEN_W-1:0]  o_arlen,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic              i_rready,
  input  logic              i_rlast,
  output logic              o_busy,
  output logic              o_done
);
  state_t            state;
  logic [ADDR_W-1:0] base, stride;
  logic [CNT_W-1:0]  count, k;
  logic              wrap, hs, rl, room, empty, last, stop;
  assign hs   = o_arvalid & i_arready;
  assign rl   = i_rvalid & i_rready & i_rlast;
  assign last = k == count - 1'b1;
  assign stop = i_stop & wrap;
  sram_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt (
    .clk    (i_aclk),
    .rst    (i_areset),
    .inc    (hs),
    .dec    (rl),
    .o_room (room),
    .o_empty(empty)
  );
  // control FSM; k indexes the address currently held in o_araddr
  always_ff @(posedge i_aclk or posedge i_areset)
    if (i_areset) begin
      state     <= IDLE;
      base      <= '0;
      stride    <= '0;
      count     <= '0;
      wrap      <= 1'b0;
      k         <= '0;
      o_araddr  <= '0;
      o_arlen   <= '0;
      o_arvalid <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (i_start) begin
            base     <= i_cfg_base;
            stride   <= i_cfg_stride;
            count    <= i_cfg_count;
            wrap     <= i_cfg_wrap;
            k        <= '0;
            o_araddr <= i_cfg_base;
            o_arlen  <= i_cfg_len;
            o_busy   <= 1'b1;
            if (i_cfg_count != '0) begin
              state     <= ISSUE;
              o_arvalid <= room;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        ISSUE:
          if (!o_arvalid || hs) begin
            if (stop || (hs && last && !wrap)) begin
              state     <= DRAIN;
              o_arvalid <= 1'b0;
            end else begin
              o_arvalid <= room;
              if (hs) begin
                k        <= last ? '0 : k + 1'b1;
                o_araddr <= last ? base : o_araddr + stride;
              end
            end
          end
        DRAIN:
          if (empty) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_sram_rd_addr_gen.sv
// tb_sram_rd_addr_gen: directed self-checking bench for the read-address generator
module tb_sram_rd_addr_gen;
  logic       clk = 1'b0, rst = 1'b0;
  logic       start = 0, stop = 0, wrap = 0, arready = 0, rvalid = 0, rready = 0, rlast = 0;
  logic [7:0] base = 0, stride = 0, len = 0, count = 0;
  logic [7:0] araddr, arlen;
  logic       arvalid, busy, done;
  int         checks = 0, failures = 0, done_n = 0;
  logic [7:0] hs_q[$];

  always #5 clk = ~clk;

  sram_rd_addr_gen dut (
    .i_aclk(clk), .i_areset(rst), .i_start(start), .i_stop(stop),
    .i_cfg_base(base), .i_cfg_stride(stride), .i_cfg_len(len), .i_cfg_count(count),
    .i_cfg_wrap(wrap), .o_araddr(araddr), .o_arlen(arlen), .o_arvalid(arvalid),
    .i_arready(arready), .i_rvalid(rvalid), .i_rready(rready), .i_rlast(rlast),
    .o_busy(busy), .o_done(done)
  );

  // record accepted addresses and completion pulses
  always @(posedge clk) begin
    if (arvalid && arready) hs_q.push_back(araddr);
    if (done) done_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic r(input logic b);
    rvalid = b; rready = b; rlast = b;
  endtask

  task automatic go(input logic [7:0] b, s, l, c, input logic w);
    hs_q.delete(); done_n = 0;
    base = b; stride = s; len = l; count = c; wrap = w; start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    #1 rst = 1;
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    cyc(2);
    rst = 0;

    // basic pass with rlast two cycles after each handshake
    arready = 1;
    go(8'h10, 8'h04, 8'h03, 8'h03, 0);
    check("t1_av0", arvalid, 1); check("t1_a0", araddr, 8'h10); check("t1_len", arlen, 3); check("t1_busy", busy, 1);
    cyc(); check("t1_a1", araddr, 8'h14); check("t1_av1", arvalid, 1);
    cyc(); check("t1_limit", arvalid, 0); r(1);
    cyc(); check("t1_av2", arvalid, 1); check("t1_a2", araddr, 8'h18);
    cyc(); check("t1_drain", arvalid, 0); r(0);
    cyc(); check("t1_nodone", done, 0); r(1);
    cyc(); r(0); check("t1_done", done, 1);
    cyc(); check("t1_done_off", done, 0); check("t1_idle", busy, 0);
    check("t1_hs_n", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("t1_hs0", hs_q[0], 8'h10); check("t1_hs1", hs_q[1], 8'h14); check("t1_hs2", hs_q[2], 8'h18);
    end
    check("t1_done_n", done_n, 1);

    // arready held low for five cycles of the first burst
    arready = 0;
    go(8'h40, 8'h00, 8'h07, 8'h01, 0);
    for (int i = 0; i < 6; i++) begin
      check("t2_hold_av", arvalid, 1); check("t2_hold_a", araddr, 8'h40); check("t2_hold_len", arlen, 7);
      if (i < 5) cyc();
    end
    arready = 1;
    cyc(); check("t2_acc", arvalid, 0); check("t2_hs_n", hs_q.size(), 1); r(1);
    cyc(); r(0); check("t2_done", done, 1);
    cyc(); check("t2_idle", busy, 0);

    // outstanding limit, release by rlast, simultaneous handshake and rlast
    go(8'h00, 8'h01, 8'h00, 8'h05, 0);
    check("t3_a0", araddr, 0);
    cyc(); check("t3_a1", araddr, 1);
    cyc(); check("t3_full", arvalid, 0);
    cyc(2); check("t3_still", arvalid, 0); check("t3_hs_n2", hs_q.size(), 2); r(1);
    cyc(); check("t3_free_av", arvalid, 1); check("t3_free_a", araddr, 2);
    cyc(); check("t3_sim_av", arvalid, 1); check("t3_sim_a", araddr, 3); r(0);
    cyc(); check("t3_sim_cnt", arvalid, 0); r(1);
    cyc(); check("t3_a4", araddr, 4); check("t3_av4", arvalid, 1);
    cyc(); check("t3_drain", arvalid, 0); check("t3_busy", busy, 1);
    cyc(); check("t3_done", done, 1); r(0);
    cyc(); check("t3_idle", busy, 0); check("t3_hs_n", hs_q.size(), 5);

    // continuous wrap mode with address wrap-around and stop
    go(8'hF8, 8'h08, 8'h00, 8'h02, 1);
    check("t4_a0", araddr, 8'hF8);
    cyc(); check("t4_a1", araddr, 8'h00); r(1);
    cyc(); check("t4_a2", araddr, 8'hF8);
    cyc(); check("t4_a3", araddr, 8'h00); check("t4_av3", arvalid, 1);
    r(0); stop = 1; arready = 0;
    cyc(); check("t4_held_av", arvalid, 1); check("t4_held_a", araddr, 8'h00); arready = 1;
    cyc(); check("t4_stopped", arvalid, 0); check("t4_busy", busy, 1); r(1);
    cyc(); check("t4_nodone", done, 0);
    cyc(); check("t4_done", done, 1); r(0); stop = 0;
    cyc(); check("t4_idle", busy, 0); check("t4_hs_n", hs_q.size(), 4);
    if (hs_q.size() == 4) begin
      check("t4_hs0", hs_q[0], 8'hF8); check("t4_hs1", hs_q[1], 8'h00);
      check("t4_hs2", hs_q[2], 8'hF8); check("t4_hs3", hs_q[3], 8'h00);
    end

    // asynchronous reset mid-burst, then a fresh start
    arready = 0;
    go(8'h20, 8'h04, 8'h02, 8'h04, 0);
    check("t5_av", arvalid, 1);
    #2 rst = 1;
    #1;
    check("t5_rst_av", arvalid, 0); check("t5_rst_a", araddr, 0); check("t5_rst_len", arlen, 0);
    check("t5_rst_busy", busy, 0); check("t5_rst_done", done, 0);
    cyc(); rst = 0; arready = 1;
    go(8'h80, 8'h00, 8'h01, 8'h01, 0);
    check("t5_new_a", araddr, 8'h80); check("t5_new_av", arvalid, 1); check("t5_new_len", arlen, 1);
    cyc(); check("t5_drain", arvalid, 0); r(1);
    cyc(); r(0); check("t5_done", done, 1);
    cyc(); check("t5_idle", busy, 0);

    // count of zero, then start while busy
    go(8'h30, 8'h10, 8'h00, 8'h00, 0);
    check("t6_z_done", done, 1); check("t6_z_av", arvalid, 0); check("t6_z_busy", busy, 1);
    cyc(); check("t6_z_off", done, 0); check("t6_z_idle", busy, 0); check("t6_z_av2", arvalid, 0);
    check("t6_z_hs", hs_q.size(), 0);
    arready = 0;
    go(8'h30, 8'h10, 8'h00, 8'h02, 0);
    check("t6_a0", araddr, 8'h30);
    base = 8'h99; count = 0; start = 1;
    cyc(); start = 0;
    check("t6_ign_a", araddr, 8'h30); check("t6_ign_av", arvalid, 1); check("t6_ign_busy", busy, 1);
    arready = 1;
    cyc(); check("t6_a1", araddr, 8'h40);
    cyc(); check("t6_drain", arvalid, 0); r(1);
    cyc(); check("t6_nodone", done, 0);
    cyc(); check("t6_done", done, 1); r(0);
    cyc(); check("t6_idle", busy, 0); check("t6_hs_n", hs_q.size(), 2); check("t6_done_n", done_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
